fetch_queue: RTL and testbench

- Instruction prefetch buffer directly downstream of the fetch stage; sits between fetch and decode.
- Accepts {instruction, pc} pairs from fetch with a valid/ready handshake and stores them in a circular FIFO.
- Presents entries in order to decode, so fetch can keep running while decode stalls.
- A flush input discards all buffered entries on a taken branch or jump (PCSrc redirect).

---
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer between the fetch and decode stages.
// Holds {instruction, pc} pairs in a circular FIFO with valid/ready handshakes
// on both sides. A flush discards every buffered entry on a redirect.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let an entry arriving at an
// empty queue reach decode in the same cycle (zero-latency bypass).
module fetch_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_WIDTH-1:0]          in_instr,
   input  logic [DATA_WIDTH-1:0]          in_pc,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_WIDTH-1:0]          out_instr,
   output logic [DATA_WIDTH-1:0]          out_pc,
   output logic [DATA_WIDTH-1:0]          out_pc_plus4,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
   localparam logic [PW-1:0]         PTR_ONE  = PW'(1);
   localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);

   logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];
   logic [DATA_WIDTH-1:0] pc_mem_r    [DEPTH];
   logic [PW-1:0]         rd_ptr_r;
   logic [PW-1:0]         wr_ptr_r;
   logic [CW-1:0]         count_r;

   logic          empty_s;
   logic          full_s;
   logic          bypass_s;
   logic          push_s;
   logic          pop_s;
   logic          wr_en_s;
   logic          rd_en_s;
   logic [PW-1:0] rd_ptr_nxt_s;
   logic [PW-1:0] wr_ptr_nxt_s;
   logic [CW-1:0] count_nxt_s;

   // Handshakes, head selection and the storage write/read enables.
   always_comb begin
      empty_s  = (count_r == {CW{1'b0}});
      full_s   = (count_r == CNT_FULL);
      bypass_s = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass_s = empty_s & ~flush & in_valid;
`else
      bypass_s = 1'b0;
`endif
      in_ready  = ~full_s & ~flush;
      out_valid = (~empty_s & ~flush) | bypass_s;
      if (bypass_s) begin
         out_instr = in_instr;
         out_pc    = in_pc;
      end else begin
         out_instr = instr_mem_r[rd_ptr_r];
         out_pc    = pc_mem_r[rd_ptr_r];
      end
      out_pc_plus4 = out_pc + PC_STEP;
      push_s  = in_valid & in_ready;
      pop_s   = out_valid & out_ready;
      // A bypassed entry that is consumed immediately never touches storage.
      wr_en_s = push_s & ~(bypass_s & out_ready);
      rd_en_s = pop_s & ~bypass_s;
      count   = count_r;
   end

   // Next pointer and occupancy values; flush overrides any handshake.
   always_comb begin
      rd_ptr_nxt_s = rd_ptr_r;
      wr_ptr_nxt_s = wr_ptr_r;
      count_nxt_s  = count_r;
      if (flush) begin
         rd_ptr_nxt_s = {PW{1'b0}};
         wr_ptr_nxt_s = {PW{1'b0}};
         count_nxt_s  = {CW{1'b0}};
      end else begin
         if (wr_en_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (rd_en_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         rd_ptr_r <= rd_ptr_nxt_s;
         wr_ptr_r <= wr_ptr_nxt_s;
         count_r  <= count_nxt_s;
      end
   end

   // Entry storage; cleared on reset so the head reads as zero afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem_r[i] <= {DATA_WIDTH{1'b0}};
            pc_mem_r[i]    <= {DATA_WIDTH{1'b0}};
         end
      end else if (wr_en_s) begin
         instr_mem_r[wr_ptr_r] <= in_instr;
         pc_mem_r[wr_ptr_r]    <= in_pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: a directed vector table, hand-written corner
// sequences (flush, mid-stream reset, streaming) and randomized traffic,
// all compared against a queue-based reference model.
module tb_fetch_queue;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_instr;
   logic [DW-1:0] in_pc;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_instr;
   logic [DW-1:0] out_pc;
   logic [DW-1:0] out_pc_plus4;
   logic [2:0]    count;

   fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc),
      .out_pc_plus4(out_pc_plus4), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] pc;
      logic        ordy;
      logic        e_ov;
      logic        e_ir;
      logic [2:0]  e_cnt;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic        chk_data;
   } vec_t;

   ent_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic model_out_valid();
      return !flush && ((q.size() != 0) || (BYPASS && in_valid));
   endfunction

   // Compare DUT outputs against the reference queue for the current inputs.
   task automatic model_check();
      logic ev;
      ent_t h;
      ev = model_out_valid();
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("in_ready", 64'(in_ready), 64'(!flush && (q.size() < DEPTH)));
      chk("count", 64'(count), 64'(q.size()));
      if (ev) begin
         if (q.size() != 0) h = q[0];
         else h = {in_instr, in_pc};
         chk("out_instr", 64'(out_instr), 64'(h.instr));
         chk("out_pc", 64'(out_pc), 64'(h.pc));
         chk("out_pc_plus4", 64'(out_pc_plus4), 64'(h.pc + 32'd4));
      end
   endtask

   // Advance the reference queue by one clock edge.
   task automatic model_update();
      logic push;
      logic pop;
      push = in_valid && !flush && (q.size() < DEPTH);
      pop  = model_out_valid() && out_ready;
      if (flush) begin
         q.delete();
      end else if (BYPASS && (q.size() == 0) && push && pop) begin
         // passes straight through, nothing stored
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back({in_instr, in_pc});
      end
   endtask

   task automatic at_neg();
      @(negedge clk);
      model_check();
   endtask

   task automatic at_pos();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
      flush     = fl;
      in_valid  = iv;
      in_pc     = pc;
      in_instr  = 32'h0050_0093 + pc;
      out_ready = ordy;
   endtask

   initial begin
      vec_t tbl[11];
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      #3;
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_pc", 64'(out_pc), 64'd0);
      chk("reset_out_instr", 64'(out_instr), 64'd0);
      chk("reset_pc_plus4", 64'(out_pc_plus4), 64'd4);
      #9;
      rst = 1'b1;
      @(posedge clk);
      #1;

`ifndef FETCH_QUEUE_BYPASS_EN
      // fl iv pc ordy | ov ir cnt instr pc chk_data  (outputs before the edge)
      tbl = '{
         '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 3'd0, 32'h0,          32'h0, 1'b1},
         '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 3'd0, 32'h0,          32'h0, 1'b1},
         '{1'b0, 1'b1, 32'h4,  1'b0, 1'b1, 1'b1, 3'd1, 32'h0050_0093,  32'h0, 1'b1},
         '{1'b0, 1'b1, 32'h8,  1'b0, 1'b1, 1'b1, 3'd2, 32'h0050_0093,  32'h0, 1'b1},
         '{1'b0, 1'b1, 32'hC,  1'b0, 1'b1, 1'b1, 3'd3, 32'h0050_0093,  32'h0, 1'b1},
         '{1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 3'd4, 32'h0050_0093,  32'h0, 1'b1},
         '{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 3'd4, 32'h0050_0093,  32'h0, 1'b1},
         '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 3'd3, 32'h0050_0097,  32'h4, 1'b1},
         '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 3'd2, 32'h0050_009B,  32'h8, 1'b1},
         '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 3'd1, 32'h0050_009F,  32'hC, 1'b1},
         '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 3'd0, 32'h0,          32'h0, 1'b0}
      };
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].ordy);
         at_neg();
         chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
         chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
         if (tbl[i].chk_data) begin
            chk($sformatf("tbl%0d_out_instr", i), 64'(out_instr), 64'(tbl[i].e_instr));
            chk($sformatf("tbl%0d_out_pc", i), 64'(out_pc), 64'(tbl[i].e_pc));
            chk($sformatf("tbl%0d_pc_plus4", i), 64'(out_pc_plus4), 64'(tbl[i].e_pc + 32'd4));
         end
         at_pos();
      end
`endif

      // Steady stream of 10 entries with both handshakes held high.
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b1, 32'h200 + 32'(4 * k), 1'b1);
         at_neg();
         if (k > 0) chk("stream_count", 64'(count), BYPASS ? 64'd0 : 64'd1);
         at_pos();
      end
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
         at_neg();
         at_pos();
      end

      // Flush with three entries held and a simultaneous push offer.
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 32'h20 + 32'(4 * k), 1'b0);
         at_neg();
         at_pos();
      end
      drive(1'b1, 1'b1, 32'h40, 1'b1);
      at_neg();
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      at_pos();
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      at_neg();
      chk("post_flush_count", 64'(count), 64'd0);
      chk("post_flush_out_valid", 64'(out_valid), 64'd0);
      at_pos();
      drive(1'b0, 1'b1, 32'h44, 1'b0);
      at_neg();
      at_pos();
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      at_neg();
      chk("post_flush_head_pc", 64'(out_pc), 64'h44);
      at_pos();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      at_neg();
      at_pos();

      // Asynchronous reset in the middle of traffic with two entries held.
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b1, 32'h80 + 32'(4 * k), 1'b0);
         at_neg();
         at_pos();
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("pre_reset_count", 64'(count), 64'd2);
      rst = 1'b0;
      #1;
      chk("midreset_count", 64'(count), 64'd0);
      chk("midreset_out_valid", 64'(out_valid), 64'd0);
      chk("midreset_in_ready", 64'(in_ready), 64'd1);
      chk("midreset_pc_plus4", 64'(out_pc_plus4), 64'd4);
      q.delete();
      #1;
      rst = 1'b1;
      drive(1'b0, 1'b1, 32'h100, 1'b0);
      at_neg();
      at_pos();
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      at_neg();
      chk("first_after_reset_pc", 64'(out_pc), 64'h100);
      at_pos();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      at_neg();
      at_pos();

      // Randomized traffic against the reference queue.
      for (int k = 0; k < 400; k++) begin
         flush     = ($urandom_range(0, 15) == 0);
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         in_pc     = $urandom;
         in_instr  = $urandom;
         at_neg();
         at_pos();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
